stoch_decode_mat: RTL



---
 rtl/stoch_decode_mat.sv | 91 +++++++++
 1 files changed

// File: rtl/stoch_decode_mat.sv
// Stochastic-to-binary matrix decoder: counts ones per element over a 2^WIN_BITS window
// and presents the whole matrix with valid/ready. Define STOCH_DECODE_BIPOLAR_EN for bipolar output.
module stoch_decode_mat #(
    parameter  int NUM_ROWS = 2,
    parameter  int NUM_COLS = 2,
    parameter  int WIN_BITS = 4,
    localparam int OUT_W    = WIN_BITS + 2
) (
    input  logic                                           CLK,
    input  logic                                           nRST,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]              A,
    input  logic                                           start,
    output logic                                           busy,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUT_W-1:0]   Y,
    output logic                                           valid,
    input  logic                                           ready
);
    // state | meaning
    // IDLE  | counters cleared, waiting for start
    // COUNT | sampling A for N cycles
    // DONE  | Y holds result, waiting for ready
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam int CW = WIN_BITS + 1;
    localparam int N  = 1 << WIN_BITS;

    state_t state, state_nxt;
    logic [WIN_BITS-1:0]                       win;
    logic                                      win_tc;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0] cnt;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0] cnt_inc;

    function automatic logic [OUT_W-1:0] decode(input logic [CW-1:0] c);
`ifdef STOCH_DECODE_BIPOLAR_EN
        decode = {c, 1'b0} - OUT_W'(N);
`else
        decode = {1'b0, c};
`endif
    endfunction

    assign win_tc = (win == '0);
    assign busy   = (state == COUNT);
    assign valid  = (state == DONE);

    always_comb begin
        for (int i = 0; i < NUM_ROWS; i++)
            for (int j = 0; j < NUM_COLS; j++)
                cnt_inc[i][j] = cnt[i][j] + {{WIN_BITS{1'b0}}, A[i][j]};
    end

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = COUNT;
            COUNT:   if (win_tc) state_nxt = DONE;
            DONE:    if (ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window counter runs down from N-1; the sample taken at terminal count is the last one.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            win <= '0;
            cnt <= '0;
            Y   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    win <= start ? WIN_BITS'(N - 1) : '0;
                end
                COUNT: begin
                    cnt <= cnt_inc;
                    win <= win - 1'b1;
                    if (win_tc) begin
                        for (int i = 0; i < NUM_ROWS; i++)
                            for (int j = 0; j < NUM_COLS; j++)
                                Y[i][j] <= decode(cnt_inc[i][j]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
